note_player: RTL and testbench

NOTE_PLAYER -- requirements
Module: note_player

---
 rtl/note_player_if.sv | 22 ++
 rtl/note_player.sv | 117 +++++++++++
 tb/tb_note_player.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/note_player_if.sv
// Control/status bundle for note_player: playback handshake, notes-table lookup and audio outputs.
interface note_player_if #(
  parameter int BW = 16
);
  logic          start_i;
  logic          stop_i;
  logic [BW-1:0] divider_value_i;
  logic [5:0]    note_index_o;
  logic          tone_o;
  logic          busy_o;
  logic          done_o;

  modport master (
    output start_i, stop_i, divider_value_i,
    input  note_index_o, tone_o, busy_o, done_o
  );

  modport slave (
    input  start_i, stop_i, divider_value_i,
    output note_index_o, tone_o, busy_o, done_o
  );
endinterface

// File: rtl/note_player.sv
// Plays a 64-slot melody as a square wave; each slot is NOTE_TICKS cycles ending in GAP_TICKS of silence.
// Define NOTE_PLAYER_LOOP_EN to wrap back to slot 0 endlessly instead of stopping after slot 63.
module note_player #(
  parameter int BW         = 16,
  parameter int TICK_BW    = 24,
  parameter int NOTE_TICKS = 1500000,
  parameter int GAP_TICKS  = 120000
) (
  input logic         clk_i,
  input logic         rst_i,
  note_player_if.slave np
);

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  localparam logic [TICK_BW-1:0] TICK_LAST = TICK_BW'(NOTE_TICKS - 1);
  localparam logic [TICK_BW-1:0] TONE_END  = TICK_BW'(NOTE_TICKS - GAP_TICKS);

  state_t             state_q, state_d;
  logic [5:0]         note_q, note_d;
  logic [TICK_BW-1:0] tick_q, tick_d;
  logic [BW-1:0]      cnt_q, cnt_d;
  logic               tone_q, tone_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    tick_d  = tick_q;
    cnt_d   = cnt_q;
    tone_d  = tone_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        note_d = '0;
        tick_d = '0;
        cnt_d  = '0;
        tone_d = 1'b0;
        busy_d = 1'b0;
        if (np.start_i && !np.stop_i) begin
          state_d = S_PLAY;
          busy_d  = 1'b1;
        end
      end
      S_PLAY: begin
        if (np.stop_i) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          note_d  = '0;
          tick_d  = '0;
          cnt_d   = '0;
          tone_d  = 1'b0;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          cnt_d  = '0;
          tone_d = 1'b0;
          if (note_q == 6'd63) begin
            note_d = '0;
            done_d = 1'b1;
`ifndef NOTE_PLAYER_LOOP_EN
            state_d = S_IDLE;
            busy_d  = 1'b0;
`endif
          end else begin
            note_d = note_q + 6'd1;
          end
        end else begin
          tick_d = tick_q + TICK_BW'(1);
          // Gate on the tick the registered tone will be visible in, so silence lines up with the gap.
          if (np.divider_value_i != '0 && tick_d < TONE_END) begin
            if (cnt_q == np.divider_value_i - BW'(1)) begin
              tone_d = ~tone_q;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_q + BW'(1);
            end
          end else begin
            tone_d = 1'b0;
            cnt_d  = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      note_q  <= '0;
      tick_q  <= '0;
      cnt_q   <= '0;
      tone_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      tone_q  <= tone_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign np.note_index_o = note_q;
  assign np.tone_o       = tone_q;
  assign np.busy_o       = busy_q;
  assign np.done_o       = done_q;

endmodule

// File: tb/tb_note_player.sv
// Randomized check of two note_player instances (8/2 and 20/4 tick slots) against a slot-arithmetic model.
module tb_note_player;

  localparam int BW = 16;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  note_player_if #(.BW(BW)) ifa ();
  note_player_if #(.BW(BW)) ifb ();

  logic [BW-1:0] tbl_a [64];
  logic [BW-1:0] tbl_b [64];

  assign ifa.divider_value_i = tbl_a[ifa.note_index_o];
  assign ifb.divider_value_i = tbl_b[ifb.note_index_o];

  note_player #(.BW(BW), .TICK_BW(24), .NOTE_TICKS(8), .GAP_TICKS(2)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .np(ifa.slave)
  );
  note_player #(.BW(BW), .TICK_BW(24), .NOTE_TICKS(20), .GAP_TICKS(4)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .np(ifb.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int nt  [2] = '{8, 20};
  int gap [2] = '{2, 4};
  bit m_play [2];
  bit m_done [2];
  int m_el   [2];

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_note(input int i);
    if (!m_play[i]) return 0;
    return (m_el[i] / nt[i]) % 64;
  endfunction

  // Square wave of half-period D restarts at each slot start: level at tick k is (k/D) mod 2.
  function automatic int exp_tone(input int i);
    int k, d;
    if (!m_play[i]) return 0;
    k = m_el[i] % nt[i];
    d = (i == 0) ? int'(tbl_a[exp_note(i)]) : int'(tbl_b[exp_note(i)]);
    if (d == 0 || k >= nt[i] - gap[i]) return 0;
    return (k / d) % 2;
  endfunction

  task automatic check_all();
    check("a_note", int'(ifa.note_index_o), exp_note(0));
    check("a_tone", int'(ifa.tone_o),       exp_tone(0));
    check("a_busy", int'(ifa.busy_o),       int'(m_play[0]));
    check("a_done", int'(ifa.done_o),       int'(m_done[0]));
    check("b_note", int'(ifb.note_index_o), exp_note(1));
    check("b_tone", int'(ifb.tone_o),       exp_tone(1));
    check("b_busy", int'(ifb.busy_o),       int'(m_play[1]));
    check("b_done", int'(ifb.done_o),       int'(m_done[1]));
  endtask

  task automatic model_step(input bit st, input bit sp);
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (!m_play[i]) begin
        if (st && !sp) begin
          m_play[i] = 1'b1;
          m_el[i]   = 0;
        end
      end else if (sp) begin
        m_play[i] = 1'b0;
        m_el[i]   = 0;
      end else begin
        m_el[i]++;
        if (m_el[i] == 64 * nt[i]) begin
          m_done[i] = 1'b1;
          m_el[i]   = 0;
`ifndef NOTE_PLAYER_LOOP_EN
          m_play[i] = 1'b0;
`endif
        end
      end
    end
  endtask

  task automatic do_cycle(input bit st, input bit sp);
    @(negedge clk_i);
    check_all();
    ifa.start_i = st; ifa.stop_i = sp;
    ifb.start_i = st; ifb.stop_i = sp;
    model_step(st, sp);
  endtask

  task automatic mid_reset();
    @(negedge clk_i);
    ifa.start_i = 1'b0; ifa.stop_i = 1'b0;
    ifb.start_i = 1'b0; ifb.stop_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      m_play[i] = 1'b0;
      m_done[i] = 1'b0;
      m_el[i]   = 0;
    end
    check("rst_a_note", int'(ifa.note_index_o), 0);
    check("rst_a_busy", int'(ifa.busy_o), 0);
    check("rst_a_tone", int'(ifa.tone_o), 0);
    check("rst_b_note", int'(ifb.note_index_o), 0);
    check("rst_b_busy", int'(ifb.busy_o), 0);
    check("rst_b_tone", int'(ifb.tone_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    for (int n = 0; n < 64; n++) begin
      tbl_a[n] = BW'($urandom_range(0, 4));
      tbl_b[n] = BW'($urandom_range(0, 6));
    end
    tbl_b[0] = BW'(2);
    tbl_a[3] = BW'(1);
    for (int i = 0; i < 2; i++) begin
      m_play[i] = 1'b0; m_done[i] = 1'b0; m_el[i] = 0;
    end
    ifa.start_i = 1'b0; ifa.stop_i = 1'b0;
    ifb.start_i = 1'b0; ifb.stop_i = 1'b0;

    #3;
    check("por_a_busy", int'(ifa.busy_o), 0);
    check("por_a_done", int'(ifa.done_o), 0);
    check("por_b_note", int'(ifb.note_index_o), 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // start, then stop at tick 5 of slot 3 of the 8-tick instance
    do_cycle(1'b1, 1'b0);
    repeat (29) do_cycle(1'b0, 1'b0);
    do_cycle(1'b0, 1'b1);
    repeat (4) do_cycle(1'b0, 1'b0);

    // start together with stop must stay idle
    do_cycle(1'b1, 1'b1);
    do_cycle(1'b0, 1'b0);

    // full play-through of both instances; stray start pulses during play
    do_cycle(1'b1, 1'b0);
    for (int c = 0; c < 1320; c++)
      do_cycle(($urandom_range(0, 40) == 0), 1'b0);

    // reset in the middle of a slot
    do_cycle(1'b1, 1'b0);
    repeat (45) do_cycle(1'b0, 1'b0);
    mid_reset();
    repeat (10) do_cycle(1'b0, 1'b0);

    // random start/stop mix with rare stops so completions still occur
    for (int c = 0; c < 3500; c++)
      do_cycle(($urandom_range(0, 30) == 0), ($urandom_range(0, 1200) == 0));

    @(negedge clk_i);
    check_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
